uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
Transmit engine for the UART core. It sits directly downstream of the 128x8 TX FIFO controller: it pops bytes through the FIFO's active-low read strobe and captures the registered FIFO output after the read latency. It then shifts each byte out LSB-first as an asynchronous serial frame: start bit, 7 or 8 data bits, optional parity bit, one stop bit. Bit timing comes from a 16x baud-rate enable pulse supplied by the baud generator.

Parameters:
RD_LAT, 2, clocks from fifo_read_n low to valid fifo_data (FIFO read_n_hold stage plus data_out register)
OVERSAMPLE, 16, baud_en pulses per serial bit

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
baud_en  input  1  one-clock enable pulse at 16x the baud rate
fifo_empty  input  1  FIFO empty flag
fifo_data  input  8  FIFO registered read data
fifo_read_n  output  1  FIFO read strobe, active low, one clock wide per byte
bit8  input  1  1 = 8 data bits, 0 = 7 data bits
parity_en  input  1  1 = append parity bit
odd_n_even  input  1  1 = odd parity, 0 = even parity
tx  output  1  serial output, idle high
tx_busy  output  1  high from pop until end of stop bit
tx_done  output  1  one-clock pulse at end of each frame

Behaviour:
- Clock and reset: one clock, "clock"; reset is synchronous and active-high, port "reset".
- Reset values: tx=1, fifo_read_n=1, tx_busy=0, tx_done=0; state=IDLE; tick counter=0; bit counter=0; shift register=0.
- Reset mid-frame: on the next edge tx returns to 1 and the state returns to IDLE. A byte already popped from the FIFO is discarded, not re-read.
- State machine: IDLE -> RD_WAIT -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - tx=1, tx_busy=0.
  - If fifo_empty=0, drive fifo_read_n=0 for exactly one clock and go to RD_WAIT.
  - Never assert fifo_read_n while fifo_empty=1.
  - The pop does not wait for baud_en.
- RD_WAIT:
  - tx_busy=1.
  - Counts RD_LAT clocks from the pop edge.
  - On the last count, capture fifo_data, bit8, parity_en and odd_n_even into local registers, set tx=0, clear the tick counter, and go to START.
  - Configuration inputs changing mid-frame have no effect until the next capture.
- Tick counter (4-bit):
  - Increments only on clocks with baud_en=1.
  - A bit ends on the clock where baud_en=1 and the counter is 15; the counter then wraps to 0.
  - Each bit therefore lasts exactly OVERSAMPLE baud_en pulses.
- START: at bit end, tx=shift[0]; go to DATA with bit counter=0.
- DATA:
  - At each bit end, shift right; tx = next bit.
  - After bit index 7 (bit8=1) or 6 (bit8=0):
    - if parity_en=1, go to PARITY with tx = parity;
    - otherwise go to STOP with tx=1.
  - In 7-bit mode fifo_data[7] is ignored.
- Parity:
  - Even: XOR of the transmitted data bits.
  - Odd: inverse of that XOR.
  - Computed over the captured byte at capture time.
- PARITY: at bit end, tx=1; go to STOP.
- STOP: at bit end, tx_done=1 for one clock, tx_busy=0, go to IDLE.
- Frame length: 16*(2+N+P) baud_en pulses, with N = 7 or 8 and P = 0 or 1.
- Back-to-back frames:
  - IDLE re-evaluates fifo_empty the clock after STOP ends.
  - The next start bit begins RD_LAT+1 clocks after tx_done, independent of baud_en phase.
- baud_en held high continuously is legal; each bit then lasts 16 clocks.

Test Plan:
- Reset, FIFO empty for 500 clocks -> fifo_read_n stays 1, tx stays 1, tx_busy=0.
- baud_en=1 every clock, 8N1, FIFO holds 0x55:
  - fifo_read_n low for exactly 1 clock; tx goes low 2 clocks later;
  - tx = 0,1,0,1,0,1,0,1,0,1, each held 16 clocks (160 clocks total);
  - tx_done pulses once.
- baud_en every 4th clock, bit8=1, parity_en=1:
  - byte 0x07, odd_n_even=0 -> parity bit 1; byte 0x07, odd_n_even=1 -> parity bit 0;
  - each bit lasts 64 clocks.
- bit8=0, parity off, byte 0xFF -> tx shows 0 then seven 1s then stop; frame is 144 baud_en pulses; bit 7 not sent.
- FIFO holds 0xA3 and 0x3C back-to-back -> exactly two read pulses; second start bit begins 3 clocks after the first tx_done; both bytes are correct LSB-first.
- Assert reset during data bit 3 of 0x00 -> next edge tx=1, tx_busy=0, state IDLE. After release with an empty FIFO there is no further read and tx stays 1.

Source files
------------

// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer_if
// Description : Read-side handshake between the TX FIFO controller and the
//               UART transmit serializer (empty flag, registered read data,
//               active-low one-clock read strobe).
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_serializer_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read_n;

  // Serializer side: consumes bytes from the FIFO
  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_read_n
  );

  // FIFO side: supplies bytes to the serializer
  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_read_n
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : UART transmit engine. Pops bytes from the TX FIFO, waits out
//               the FIFO read latency, then shifts the byte out LSB-first as
//               start / 7 or 8 data / optional parity / stop, timed by a 16x
//               baud-rate enable pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
  parameter int RD_LAT     = 2,
  parameter int OVERSAMPLE = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        baud_en,
  uart_tx_serializer_if.master        fifo,
  input  logic                        bit8,
  input  logic                        parity_en,
  input  logic                        odd_n_even,
  output logic                        tx,
  output logic                        tx_busy,
  output logic                        tx_done
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [3:0]        RD_LAST   = 4'(RD_LAT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_START   = 3'd2,
    S_DATA    = 3'd3,
    S_PARITY  = 3'd4,
    S_STOP    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;   // read-latency count in RD_WAIT, bit index in DATA
  logic [7:0]        shift_q, shift_d;
  logic              bit8_q, bit8_d;
  logic              par_en_q, par_en_d;
  logic              par_q, par_d;           // parity bit value, fixed at capture
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_n_q, rd_n_d;

  logic              in_frame;
  logic              bit_end;
  logic [3:0]        last_idx;
  logic              cap_parity;

  assign in_frame   = (state_q == S_START) || (state_q == S_DATA) ||
                      (state_q == S_PARITY) || (state_q == S_STOP);
  assign bit_end    = in_frame && baud_en && (tick_q == TICK_LAST);
  assign last_idx   = bit8_q ? 4'd7 : 4'd6;
  // In 7-bit mode the MSB is never sent, so it must not affect parity
  assign cap_parity = (^(fifo.fifo_data & (bit8 ? 8'hFF : 8'h7F))) ^ odd_n_even;

  // Register every piece of state; synchronous reset drops any frame in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      bit8_q    <= 1'b0;
      par_en_q  <= 1'b0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      bit8_q    <= bit8_d;
      par_en_q  <= par_en_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_n_q    <= rd_n_d;
    end
  end

  // Next-state and registered-output logic for the frame sequencer
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    bit8_d    = bit8_q;
    par_en_d  = par_en_q;
    par_d     = par_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_n_d    = 1'b1;

    // Oversample counter runs only while a frame is on the line
    if (in_frame && baud_en) begin
      tick_d = bit_end ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        // Pop immediately; the baud phase does not gate the read
        if (!fifo.fifo_empty) begin
          rd_n_d    = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = 4'd1;     // the pop edge is the first latency clock
          state_d   = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        if (bit_cnt_q >= RD_LAST) begin
          shift_d   = fifo.fifo_data;
          bit8_d    = bit8;
          par_en_d  = parity_en;
          par_d     = cap_parity;
          tx_d      = 1'b0;
          tick_d    = '0;
          bit_cnt_d = '0;
          state_d   = S_START;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end

      S_START: begin
        if (bit_end) begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == last_idx) begin
            if (par_en_q) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx               = tx_q;
  assign tx_busy          = busy_q;
  assign tx_done          = done_q;
  assign fifo.fifo_read_n = rd_n_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_serializer
// Description : Self-checking bench for uart_tx_serializer with a queue-based
//               FIFO model and a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic baud_en = 1'b0;
  logic bit8 = 1'b1;
  logic parity_en = 1'b0;
  logic odd_n_even = 1'b0;
  logic tx, tx_busy, tx_done;

  uart_tx_serializer_if fifo_if();

  uart_tx_serializer #(.RD_LAT(2), .OVERSAMPLE(16)) dut (
    .clock      (clk),
    .reset      (reset),
    .baud_en    (baud_en),
    .fifo       (fifo_if),
    .bit8       (bit8),
    .parity_en  (parity_en),
    .odd_n_even (odd_n_even),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  byte unsigned fifo_q[$];
  int  cyc = 0;
  int  baud_period = 1;
  int  baud_phase = 0;
  bit  scramble = 1'b0;

  // monitor state
  int  n_rd, rd_low_total, n_done, nf, pop_empty;
  bit  in_frame = 1'b0;
  bit  prev_rd = 1'b1;
  int  rd_low_cyc[4];
  int  tx_low_c[4];
  int  done_c[4];
  bit  samp[4][200];
  int  samp_n[4];

  task automatic push(input byte unsigned b);
    fifo_q.push_back(b);
    fifo_if.fifo_empty = 1'b0;
  endtask

  task automatic clear_mon();
    n_rd = 0; rd_low_total = 0; n_done = 0; nf = 0; pop_empty = 0;
    in_frame = 1'b0;
    for (int i = 0; i < 4; i++) begin
      samp_n[i] = 0; rd_low_cyc[i] = 0; tx_low_c[i] = 0; done_c[i] = 0;
    end
  endtask

  // One clock: FIFO model, line monitor, baud pulse generation
  task automatic step();
    bit tx_b = tx;
    bit be   = baud_en;
    bit rd_b = fifo_if.fifo_read_n;
    @(posedge clk);
    #1;
    cyc++;
    if (!rd_b) begin
      if (fifo_q.size() > 0) fifo_if.fifo_data = fifo_q.pop_front();
      else pop_empty++;
    end
    fifo_if.fifo_empty = (fifo_q.size() == 0);
    if (in_frame && be && nf < 4 && samp_n[nf] < 200) begin
      samp[nf][samp_n[nf]] = tx_b;
      samp_n[nf]++;
    end
    if (!fifo_if.fifo_read_n) begin
      rd_low_total++;
      if (prev_rd) begin
        if (n_rd < 4) rd_low_cyc[n_rd] = cyc;
        n_rd++;
      end
    end
    prev_rd = fifo_if.fifo_read_n;
    if (!in_frame && tx === 1'b0 && tx_busy === 1'b1) begin
      in_frame = 1'b1;
      if (nf < 4) tx_low_c[nf] = cyc;
    end
    if (tx_done === 1'b1) begin
      n_done++;
      if (in_frame) begin
        if (nf < 4) done_c[nf] = cyc;
        nf++;
      end
      in_frame = 1'b0;
    end
    if (reset) in_frame = 1'b0;
    if (scramble && in_frame) {bit8, parity_en, odd_n_even} = 3'($urandom);
    baud_en = (baud_period <= 1) ? 1'b1 : (((cyc + baud_phase) % baud_period) == 0);
  endtask

  task automatic run_stream(input int nfr, input int bound, input int tail, output bit timed_out);
    int k = 0;
    clear_mon();
    while (nf < nfr && k < bound) begin
      step();
      k++;
    end
    timed_out = (nf < nfr);
    repeat (tail) step();
  endtask

  // Reference frame: start, N data bits LSB-first, optional parity, stop
  task automatic model_frame(input byte unsigned d, input bit b8, input bit pe, input bit odd,
                             output bit bits[11], output int nb);
    int n = b8 ? 8 : 7;
    int ones = 0;
    for (int i = 0; i < 11; i++) bits[i] = 1'b1;
    bits[0] = 1'b0;
    for (int i = 0; i < n; i++) begin
      bits[1 + i] = d[i];
      ones += d[i];
    end
    nb = 1 + n;
    if (pe) begin
      bits[nb] = ((ones % 2) == 1) ^ odd;
      nb++;
    end
    bits[nb] = 1'b1;
    nb++;
  endtask

  // Number of per-pulse line samples in frame f that differ from the model
  function automatic int sample_errs(input int f, input bit bits[11], input int nb);
    int errs = 0;
    for (int i = 0; i < samp_n[f]; i++) begin
      int idx = i / 16;
      bit exp_b = (idx < nb) ? bits[idx] : 1'b1;
      if (samp[f][i] !== exp_b) errs++;
    end
    return errs;
  endfunction

  task automatic test_reset();
    int bad_tx = 0, bad_busy = 0;
    reset = 1'b1;
    repeat (3) step();
    checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx); else passed++;
    checks++; if (fifo_if.fifo_read_n !== 1'b1) $display("FAIL reset_read_n: got %b expected 1", fifo_if.fifo_read_n); else passed++;
    checks++; if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", tx_busy); else passed++;
    checks++; if (tx_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", tx_done); else passed++;
    reset = 1'b0;
    clear_mon();
    for (int i = 0; i < 500; i++) begin
      step();
      if (tx !== 1'b1) bad_tx++;
      if (tx_busy !== 1'b0) bad_busy++;
    end
    checks++; if (n_rd !== 0) $display("FAIL empty_reads: got %0d expected 0", n_rd); else passed++;
    checks++; if (bad_tx !== 0) $display("FAIL empty_tx_idle: got %0d low clocks expected 0", bad_tx); else passed++;
    checks++; if (bad_busy !== 0) $display("FAIL empty_busy: got %0d busy clocks expected 0", bad_busy); else passed++;
  endtask

  task automatic test_8n1();
    bit bits[11]; int nb; bit to;
    baud_period = 1; scramble = 1'b0;
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    model_frame(8'h55, 1'b1, 1'b0, 1'b0, bits, nb);
    push(8'h55);
    run_stream(1, 400, 10, to);
    checks++; if (to) $display("FAIL 8n1_timeout: got no tx_done expected 1"); else passed++;
    checks++; if (n_rd !== 1) $display("FAIL 8n1_reads: got %0d expected 1", n_rd); else passed++;
    checks++; if (rd_low_total !== 1) $display("FAIL 8n1_read_width: got %0d expected 1", rd_low_total); else passed++;
    checks++; if (tx_low_c[0] - rd_low_cyc[0] !== 2) $display("FAIL 8n1_start_delay: got %0d expected 2", tx_low_c[0] - rd_low_cyc[0]); else passed++;
    checks++; if (done_c[0] - tx_low_c[0] !== 160) $display("FAIL 8n1_frame_clocks: got %0d expected 160", done_c[0] - tx_low_c[0]); else passed++;
    checks++; if (samp_n[0] !== 16 * nb) $display("FAIL 8n1_pulses: got %0d expected %0d", samp_n[0], 16 * nb); else passed++;
    checks++; if (sample_errs(0, bits, nb) !== 0) $display("FAIL 8n1_bits: got %0d bad samples expected 0", sample_errs(0, bits, nb)); else passed++;
    checks++; if (n_done !== 1) $display("FAIL 8n1_done_pulses: got %0d expected 1", n_done); else passed++;
  endtask

  task automatic test_parity();
    bit bits[11]; int nb; bit to;
    bit exp_par[2] = '{1'b1, 1'b0};
    baud_period = 4; scramble = 1'b0;
    for (int k = 0; k < 2; k++) begin
      baud_phase = $urandom_range(0, 3);
      bit8 = 1'b1; parity_en = 1'b1; odd_n_even = k[0];
      model_frame(8'h07, 1'b1, 1'b1, k[0], bits, nb);
      push(8'h07);
      run_stream(1, 1500, 4, to);
      checks++; if (to) $display("FAIL parity%0d_timeout: got no tx_done expected 1", k); else passed++;
      checks++; if (samp_n[0] !== 16 * nb) $display("FAIL parity%0d_pulses: got %0d expected %0d", k, samp_n[0], 16 * nb); else passed++;
      checks++; if (sample_errs(0, bits, nb) !== 0) $display("FAIL parity%0d_bits: got %0d bad samples expected 0", k, sample_errs(0, bits, nb)); else passed++;
      checks++; if (samp[0][16 * 9 + 8] !== exp_par[k]) $display("FAIL parity%0d_value: got %b expected %b", k, samp[0][16 * 9 + 8], exp_par[k]); else passed++;
      checks++;
      if ((done_c[0] - tx_low_c[0]) < 701 || (done_c[0] - tx_low_c[0]) > 704)
        $display("FAIL parity%0d_frame_clocks: got %0d expected 701..704", k, done_c[0] - tx_low_c[0]);
      else passed++;
    end
  endtask

  task automatic test_7bit();
    bit bits[11]; int nb; bit to;
    baud_period = $urandom_range(1, 3); baud_phase = $urandom_range(0, 2); scramble = 1'b0;
    bit8 = 1'b0; parity_en = 1'b0; odd_n_even = 1'b0;
    model_frame(8'hFF, 1'b0, 1'b0, 1'b0, bits, nb);
    push(8'hFF);
    run_stream(1, 1000, 4, to);
    checks++; if (to) $display("FAIL 7bit_timeout: got no tx_done expected 1"); else passed++;
    checks++; if (samp_n[0] !== 144) $display("FAIL 7bit_pulses: got %0d expected 144", samp_n[0]); else passed++;
    checks++; if (sample_errs(0, bits, nb) !== 0) $display("FAIL 7bit_bits: got %0d bad samples expected 0", sample_errs(0, bits, nb)); else passed++;
  endtask

  task automatic test_back_to_back();
    bit b0[11]; bit b1[11]; int n0, n1; bit to;
    baud_period = 2; baud_phase = $urandom_range(0, 1); scramble = 1'b0;
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    model_frame(8'hA3, 1'b1, 1'b0, 1'b0, b0, n0);
    model_frame(8'h3C, 1'b1, 1'b0, 1'b0, b1, n1);
    push(8'hA3);
    push(8'h3C);
    run_stream(2, 1500, 10, to);
    checks++; if (to) $display("FAIL b2b_timeout: got %0d frames expected 2", nf); else passed++;
    checks++; if (n_rd !== 2) $display("FAIL b2b_reads: got %0d expected 2", n_rd); else passed++;
    checks++; if (tx_low_c[1] - done_c[0] !== 3) $display("FAIL b2b_gap: got %0d expected 3", tx_low_c[1] - done_c[0]); else passed++;
    checks++; if (samp_n[0] !== 160 || samp_n[1] !== 160) $display("FAIL b2b_pulses: got %0d,%0d expected 160,160", samp_n[0], samp_n[1]); else passed++;
    checks++; if (sample_errs(0, b0, n0) !== 0) $display("FAIL b2b_bits_a3: got %0d bad samples expected 0", sample_errs(0, b0, n0)); else passed++;
    checks++; if (sample_errs(1, b1, n1) !== 0) $display("FAIL b2b_bits_3c: got %0d bad samples expected 0", sample_errs(1, b1, n1)); else passed++;
  endtask

  task automatic test_reset_mid();
    bit bits[11]; int nb; bit to;
    int k = 0, bad_tx = 0;
    baud_period = 1; scramble = 1'b0;
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    push(8'h00);
    clear_mon();
    while (!in_frame && k < 50) begin step(); k++; end
    checks++; if (!in_frame) $display("FAIL rstmid_start: got no start bit expected start"); else passed++;
    repeat (72) step();   // middle of data bit 3
    checks++; if (tx !== 1'b0) $display("FAIL rstmid_bit3: got %b expected 0", tx); else passed++;
    reset = 1'b1;
    step();
    checks++; if (tx !== 1'b1) $display("FAIL rstmid_tx: got %b expected 1", tx); else passed++;
    checks++; if (tx_busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", tx_busy); else passed++;
    reset = 1'b0;
    clear_mon();
    for (int i = 0; i < 200; i++) begin
      step();
      if (tx !== 1'b1) bad_tx++;
    end
    checks++; if (n_rd !== 0 || pop_empty !== 0) $display("FAIL rstmid_reads: got %0d expected 0", n_rd + pop_empty); else passed++;
    checks++; if (bad_tx !== 0) $display("FAIL rstmid_idle_tx: got %0d low clocks expected 0", bad_tx); else passed++;
    // Engine must be back in idle and able to send a fresh byte
    model_frame(8'h5A, 1'b1, 1'b0, 1'b0, bits, nb);
    push(8'h5A);
    run_stream(1, 400, 4, to);
    checks++; if (to || sample_errs(0, bits, nb) !== 0 || samp_n[0] !== 160)
      $display("FAIL rstmid_recover: got %0d samples expected 160 clean", samp_n[0]);
    else passed++;
  endtask

  task automatic test_random();
    bit bits[11]; int nb; bit to;
    byte unsigned d; bit b8, pe, odd;
    for (int f = 0; f < 6; f++) begin
      d = 8'($urandom); b8 = 1'($urandom); pe = 1'($urandom); odd = 1'($urandom);
      baud_period = $urandom_range(1, 3); baud_phase = $urandom_range(0, 2);
      scramble = 1'b1;
      bit8 = b8; parity_en = pe; odd_n_even = odd;
      model_frame(d, b8, pe, odd, bits, nb);
      push(d);
      run_stream(1, 1500, 3, to);
      scramble = 1'b0;
      checks++;
      if (to || samp_n[0] !== 16 * nb || n_rd !== 1)
        $display("FAIL rand%0d_shape: got %0d pulses %0d reads expected %0d pulses 1 read", f, samp_n[0], n_rd, 16 * nb);
      else passed++;
      checks++;
      if (sample_errs(0, bits, nb) !== 0)
        $display("FAIL rand%0d_bits: got %0d bad samples expected 0 (byte %h b8 %b pe %b odd %b)", f, sample_errs(0, bits, nb), d, b8, pe, odd);
      else passed++;
    end
  endtask

  initial begin
    fifo_if.fifo_empty = 1'b1;
    fifo_if.fifo_data  = 8'h00;
    test_reset();
    test_8n1();
    test_parity();
    test_7bit();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
